// File: rtl/track_countdown_overlay.sv
// BCD countdown timer with a 3x5-font digit overlay for the 96x64 OLED pixel pipeline.
// Digits blink at a tick-based rate once the count has expired.
module track_countdown_overlay #(
  parameter int          X_POS       = 80,
  parameter int          NUM_DIGITS  = 2,
  parameter logic [15:0] START_VALUE = 16'h0003,
  parameter int          BLINK_TICKS = 2,
  parameter int          LEAD_ZERO   = 0,
  parameter logic [15:0] FG_COLOR    = 16'h0000,
  parameter logic [15:0] BG_COLOR    = 16'hFDDB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        tick,
  input  logic [6:0]  y_pos,
  input  logic [12:0] pix_index,
  output logic [15:0] oled,
  output logic [15:0] value,
  output logic        running,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  localparam logic [15:0] DIGIT_MASK  = 16'((32'd1 << (4 * NUM_DIGITS)) - 32'd1);
  localparam logic [15:0] START_LOAD  = START_VALUE & DIGIT_MASK;
  localparam logic [7:0]  BLINK_LIMIT = 8'(BLINK_TICKS);

  state_t      state, state_nxt;
  logic [15:0] value_nxt, value_dec;
  logic [7:0]  blink_cnt, blink_nxt;
  logic        visible, visible_nxt, done_nxt;

  logic [7:0]  px, py, y_top, col_base;
  logic [3:0]  nib;
  logic [2:0]  font_bits;
  logic [1:0]  col_off;
  logic        lead_zero_run, blank, pixel_on;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r & DIGIT_MASK;
  endfunction

  // Glyph rows packed top-to-bottom, MSB of each row is the left column; non-BCD renders blank.
  function automatic logic [2:0] font_row(input logic [3:0] d, input logic [2:0] row);
    logic [14:0] g;
    logic [2:0]  r;
    case (d)
      4'd0:    g = 15'b111_101_101_101_111;
      4'd1:    g = 15'b110_010_010_010_111;
      4'd2:    g = 15'b111_001_111_100_111;
      4'd3:    g = 15'b111_001_111_001_111;
      4'd4:    g = 15'b101_101_111_001_001;
      4'd5:    g = 15'b111_100_111_001_111;
      4'd6:    g = 15'b111_100_111_101_111;
      4'd7:    g = 15'b111_001_001_001_001;
      4'd8:    g = 15'b111_101_111_101_111;
      4'd9:    g = 15'b111_101_111_001_111;
      default: g = 15'b0;
    endcase
    case (row)
      3'd0:    r = g[14:12];
      3'd1:    r = g[11:9];
      3'd2:    r = g[8:6];
      3'd3:    r = g[5:3];
      3'd4:    r = g[2:0];
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      value     <= 16'h0000;
      blink_cnt <= 8'd0;
      visible   <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      value     <= value_nxt;
      blink_cnt <= blink_nxt;
      visible   <= visible_nxt;
      done      <= done_nxt;
    end
  end

  // start overrides everything, so a coincident tick is simply never looked at.
  always_comb begin
    state_nxt   = state;
    value_nxt   = value;
    blink_nxt   = blink_cnt;
    visible_nxt = visible;
    done_nxt    = 1'b0;
    value_dec   = bcd_dec(value);
    if (start) begin
      value_nxt   = START_LOAD;
      blink_nxt   = 8'd0;
      visible_nxt = 1'b1;
      if (START_LOAD == 16'h0000) begin
        state_nxt = EXPIRED;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (tick && !pause) begin
            value_nxt = value_dec;
            if (value_dec == 16'h0000) begin
              state_nxt   = EXPIRED;
              done_nxt    = 1'b1;
              visible_nxt = 1'b1;
              blink_nxt   = 8'd0;
            end
          end
        end
        EXPIRED: begin
          if (tick) begin
            if (blink_cnt + 8'd1 == BLINK_LIMIT) begin
              blink_nxt   = 8'd0;
              visible_nxt = !visible;
            end else begin
              blink_nxt = blink_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign running = (state == RUN) && !pause;

  assign px    = 8'(pix_index % 13'd96);
  assign py    = 8'(pix_index / 13'd96);
  assign y_top = {1'b0, y_pos};

  // Walk digits from most to least significant so leading-zero state accumulates in order.
  always_comb begin
    pixel_on      = 1'b0;
    lead_zero_run = 1'b1;
    blank         = 1'b0;
    nib           = 4'd0;
    font_bits     = 3'b000;
    col_base      = 8'd0;
    col_off       = 2'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib           = value[4*i +: 4];
      lead_zero_run = lead_zero_run && (nib == 4'd0);
      blank         = (LEAD_ZERO == 0) && lead_zero_run && (i > 0);
      col_base      = 8'(X_POS + 4 * (NUM_DIGITS - 1 - i));
      if (!blank && px >= col_base && px < col_base + 8'd3 &&
          py >= y_top && py <= y_top + 8'd4) begin
        font_bits = font_row(nib, 3'(py - y_top));
        col_off   = 2'(px - col_base);
        if (font_bits[2'd2 - col_off]) pixel_on = 1'b1;
      end
    end
    if (state == IDLE || (state == EXPIRED && !visible)) pixel_on = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oled <= BG_COLOR;
    else     oled <= pixel_on ? FG_COLOR : BG_COLOR;
  end

endmodule

// File: tb/tb_track_countdown_overlay.sv
// Self-checking bench for track_countdown_overlay: table-driven vectors on a default
// instance plus hand sequences on a second instance loaded with 16'h0010.
module tb_track_countdown_overlay;

  localparam logic [15:0] FG = 16'h0000;
  localparam logic [15:0] BG = 16'hFDDB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [6:0]  y_pos = 7'd10;
  logic [12:0] pix_index = 13'd0;
  logic [15:0] oled_a, value_a, oled_b, value_b;
  logic        running_a, done_a, running_b, done_b;

  track_countdown_overlay dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pause(pause), .tick(tick),
    .y_pos(y_pos), .pix_index(pix_index),
    .oled(oled_a), .value(value_a), .running(running_a), .done(done_a)
  );

  track_countdown_overlay #(.START_VALUE(16'h0010)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(pause), .tick(tick),
    .y_pos(y_pos), .pix_index(pix_index),
    .oled(oled_b), .value(value_b), .running(running_b), .done(done_b)
  );

  always #5 clk = ~clk;

  typedef enum int {S_VAL_A, S_DONE_A, S_RUN_A, S_OLED_A, S_VAL_B, S_DONE_B, S_RUN_B, S_OLED_B} sig_t;

  typedef struct {
    string       name;
    sig_t        sig;
    logic [15:0] exp;
  } sb_t;

  typedef struct {
    logic        start, pause, tick;
    int          x, y;
    logic [15:0] exp_value;
    logic        exp_done, exp_running, exp_fg;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic s, logic p, logic t, int x, int y,
                              logic [15:0] v, logic d, logic r, logic fg);
    vec_t e;
    e.start = s; e.pause = p; e.tick = t; e.x = x; e.y = y;
    e.exp_value = v; e.exp_done = d; e.exp_running = r; e.exp_fg = fg;
    return e;
  endfunction

  function automatic logic [15:0] observe(sig_t s);
    case (s)
      S_VAL_A:  return value_a;
      S_DONE_A: return {15'd0, done_a};
      S_RUN_A:  return {15'd0, running_a};
      S_OLED_A: return oled_a;
      S_VAL_B:  return value_b;
      S_DONE_B: return {15'd0, done_b};
      S_RUN_B:  return {15'd0, running_b};
      default:  return oled_b;
    endcase
  endfunction

  task automatic expect_sig(input string name, input sig_t s, input logic [15:0] exp);
    sb_t e;
    e.name = name; e.sig = s; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic s_a, input logic s_b, input logic p,
                               input logic t, input int x, input int y);
    start_a   = s_a;
    start_b   = s_b;
    pause     = p;
    tick      = t;
    pix_index = 13'(y * 96 + x);
  endtask

  task automatic checkOutput();
    sb_t         e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.sig);
      n_vec++;
      if (got !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", e.name, got, e.exp, $time);
      end
    end
  endtask

  task automatic clock_and_check();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // start, pause, tick, x, y, value, done, running, fg
    vecs.push_back(mk(0,0,0, 84,10, 16'h00,0,0,0));
    vecs.push_back(mk(1,0,0, 84,10, 16'h03,0,1,0));
    vecs.push_back(mk(0,0,0, 84,10, 16'h03,0,1,1));
    vecs.push_back(mk(0,0,0, 80,10, 16'h03,0,1,0));
    vecs.push_back(mk(0,0,1, 84,11, 16'h02,0,1,0));
    vecs.push_back(mk(0,0,1, 86,11, 16'h01,0,1,1));
    vecs.push_back(mk(0,0,1, 85,10, 16'h00,1,0,1));
    vecs.push_back(mk(0,0,0, 84,10, 16'h00,0,0,1));
    vecs.push_back(mk(0,0,0, 85,11, 16'h00,0,0,0));
    vecs.push_back(mk(0,0,1, 84,12, 16'h00,0,0,1));
    vecs.push_back(mk(0,0,1, 84,12, 16'h00,0,0,1));
    vecs.push_back(mk(0,0,1, 84,12, 16'h00,0,0,0));
    vecs.push_back(mk(0,0,1, 84,12, 16'h00,0,0,0));
    vecs.push_back(mk(0,0,0, 84,12, 16'h00,0,0,1));
    vecs.push_back(mk(0,0,0, 83,10, 16'h00,0,0,0));
    vecs.push_back(mk(0,0,0, 84,15, 16'h00,0,0,0));
    vecs.push_back(mk(1,0,0,  0, 0, 16'h03,0,1,0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0,1,1, 84,10, 16'h03,0,0,1));
    vecs.push_back(mk(0,0,1, 84,14, 16'h02,0,1,1));
    vecs.push_back(mk(1,0,1, 86,12, 16'h03,0,1,1));

    #1 rst = 1'b1;
    #1;
    expect_sig("reset value_a", S_VAL_A, 16'h0000);
    expect_sig("reset oled_a", S_OLED_A, BG);
    expect_sig("reset done_a", S_DONE_A, 16'h0000);
    expect_sig("reset running_a", S_RUN_A, 16'h0000);
    expect_sig("reset value_b", S_VAL_B, 16'h0000);
    checkOutput();
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, 1'b0, vecs[i].pause, vecs[i].tick, vecs[i].x, vecs[i].y);
      expect_sig($sformatf("vec%0d value", i), S_VAL_A, vecs[i].exp_value);
      expect_sig($sformatf("vec%0d done", i), S_DONE_A, {15'd0, vecs[i].exp_done});
      expect_sig($sformatf("vec%0d running", i), S_RUN_A, {15'd0, vecs[i].exp_running});
      expect_sig($sformatf("vec%0d oled", i), S_OLED_A, vecs[i].exp_fg ? FG : BG);
      clock_and_check();
    end

    // Block near the bottom edge: rows 62..66 must not wrap onto rows 0..2.
    y_pos = 7'd62;
    applyStimulus(0, 0, 0, 0, 84, 62);
    expect_sig("y62 top row", S_OLED_A, FG);
    clock_and_check();
    applyStimulus(0, 0, 0, 0, 86, 63);
    expect_sig("y63 row1 right", S_OLED_A, FG);
    clock_and_check();
    for (int r = 0; r < 3; r++) begin
      applyStimulus(0, 0, 0, 0, 84, r);
      expect_sig($sformatf("no wrap row %0d", r), S_OLED_A, BG);
      clock_and_check();
    end

    y_pos = 7'd10;
    applyStimulus(0, 1, 0, 0, 84, 10);
    expect_sig("b start value", S_VAL_B, 16'h0010);
    expect_sig("b start done", S_DONE_B, 16'h0000);
    clock_and_check();
    applyStimulus(0, 0, 0, 1, 80, 10);
    expect_sig("b borrow value", S_VAL_B, 16'h0009);
    expect_sig("b digit0 '1' drawn", S_OLED_B, FG);
    clock_and_check();
    applyStimulus(0, 0, 0, 0, 80, 10);
    expect_sig("b lead zero blank", S_OLED_B, BG);
    clock_and_check();
    applyStimulus(0, 0, 0, 0, 84, 10);
    expect_sig("b digit1 '9' drawn", S_OLED_B, FG);
    expect_sig("b running", S_RUN_B, 16'h0001);
    clock_and_check();
    for (int k = 8; k >= 5; k--) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      expect_sig($sformatf("b count %0d", k), S_VAL_B, 16'(k));
      clock_and_check();
    end
    applyStimulus(0, 1, 0, 1, 0, 0);
    expect_sig("b start beats tick", S_VAL_B, 16'h0010);
    expect_sig("b start beats tick done", S_DONE_B, 16'h0000);
    clock_and_check();

    applyStimulus(0, 0, 0, 0, 80, 10);
    expect_sig("b pre-reset fg", S_OLED_B, FG);
    clock_and_check();
    #2 rst = 1'b1;
    #1;
    expect_sig("async rst oled_b", S_OLED_B, BG);
    expect_sig("async rst value_b", S_VAL_B, 16'h0000);
    expect_sig("async rst done_b", S_DONE_B, 16'h0000);
    expect_sig("async rst running_b", S_RUN_B, 16'h0000);
    expect_sig("async rst value_a", S_VAL_A, 16'h0000);
    checkOutput();
    #2 rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 80, 10);
    expect_sig("idle after rst oled_b", S_OLED_B, BG);
    expect_sig("idle ignores tick", S_VAL_B, 16'h0000);
    clock_and_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/track_countdown_overlay.md
# track_countdown_overlay

Parametrised countdown timer with a built-in 96x64 OLED digit renderer. It holds an NUM_DIGITS-wide BCD count, decrements it once per `tick` strobe, pauses and resumes on request, and reports expiry. It draws the count in a 3x5 font at a fixed column and a run-time row for the OLED pixel pipeline, and blinks the digits after expiry. It is the successor to the fixed single-digit 3-to-0 overlay used in the track screens.

## Interface
- `X_POS`, 80: leftmost column of digit 0, the most significant digit.
- `NUM_DIGITS`, 2: number of BCD digits; legal range 1..4.
- `START_VALUE`, 16'h0003: BCD value loaded on `start`; only the low 4*NUM_DIGITS bits are used.
- `BLINK_TICKS`, 2: number of `tick` strobes per blink half-period while expired; legal range 1..255.
- `LEAD_ZERO`, 0: 1 draws leading zeros; 0 blanks leading zeros except the least significant digit.
- `FG_COLOR`, 16'h0000: RGB565 colour of digit pixels.
- `BG_COLOR`, 16'hFDDB: RGB565 colour of every other pixel.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: loads START_VALUE and begins counting; accepted in every state.
- `pause` input 1: level signal; while high, ticks are ignored in RUN.
- `tick` input 1: one-cycle decrement strobe, for example 1 Hz.
- `y_pos` input 7: top row of the digit block.
- `pix_index` input 13: pixel index; x = pix_index % 96, y = pix_index / 96.
- `oled` output 16: registered pixel colour.
- `value` output 16: current BCD count; unused high nibbles are 0.
- `running` output 1: high in RUN while `pause` is low.
- `done` output 1: one-cycle pulse on entry to EXPIRED.

## Operation
- States and reset:
  - Four states: IDLE, RUN, EXPIRED, plus PAUSE_VIEW. PAUSE_VIEW is not stored; it is RUN with `pause` high.
  - Reset: state = IDLE, `value` = 0, `oled` = BG_COLOR, `done` = 0, `running` = 0, blink counter = 0, `visible` = 1.
- `start` (any state, highest priority after rst):
  - Loads `value` = START_VALUE and clears the blink counter.
  - If START_VALUE is 0: state goes to EXPIRED and `done` pulses.
  - Otherwise: state goes to RUN.
  - If `start` and `tick` arrive in the same cycle, `start` wins and that tick is dropped.
- RUN, `tick` high and `pause` low:
  - `value` takes a BCD decrement with borrow; a digit at 0 becomes 9 and borrows from the next digit.
  - If the result is 0: state goes to EXPIRED, `done` = 1 for exactly one cycle, and `visible` = 1.
- EXPIRED:
  - `value` holds at 0 and further ticks never decrement.
  - Each tick increments the blink counter. When it reaches BLINK_TICKS, `visible` toggles and the counter clears.
  - Exit only on `start` or `rst`.
- IDLE: digits are not drawn and `oled` = BG_COLOR.
- Rendering:
  - Digit d occupies columns X_POS+4d .. X_POS+4d+2 and rows y_pos .. y_pos+4.
  - Row/column compares use 8-bit arithmetic, so y_pos+4 never wraps; rows above 63 simply never match.
  - Font rows, top to bottom, each row 3 bits with the MSB as the left column:
    - 0 = 111,101,101,101,111
    - 1 = 110,010,010,010,111
    - 2 = 111,001,111,100,111
    - 3 = 111,001,111,001,111
    - 4 = 101,101,111,001,001
    - 5 = 111,100,111,001,111
    - 6 = 111,100,111,101,111
    - 7 = 111,001,001,001,001
    - 8 = 111,101,111,101,111
    - 9 = 111,101,111,001,111
  - A pixel is FG_COLOR only when all of these hold: state is not IDLE, the pixel is inside a digit cell, the font bit is 1, the digit is not blanked, and (state is not EXPIRED or `visible` = 1).
  - Leading-zero blanking: with LEAD_ZERO = 0, digit d is blanked when it and all more significant digits are 0 and d < NUM_DIGITS-1.
  - Non-BCD nibbles (A-F) cannot occur internally; if they did, they render blank.

## Timing
- `oled` has 1-cycle latency: it is registered from the `pix_index` sampled at the previous edge, using the pre-edge `value`, state and `visible`.
- `value`, state and `done` update on the clock edge that samples `tick` or `start`.
- `done` is high for exactly the one cycle following that edge.
- `rst` asserted mid-count forces all outputs to their reset values immediately, without waiting for a clock.
- `pause` takes effect on the same edge: a tick coincident with `pause` high is ignored.

## Test plan
- rst, then `start` with defaults, then 3 ticks: `value` goes 03→02→01→00; `done` pulses once, in the cycle after the third tick; state is EXPIRED.
- START_VALUE = 16'h0010, NUM_DIGITS = 2, one tick: `value` = 16'h0009 (borrow). With LEAD_ZERO = 0, the pixel at x=80, y=y_pos is BG_COLOR and the pixel at x=84, y=y_pos is FG_COLOR.
- `pause` high while 5 ticks arrive: `value` unchanged and `running` = 0. Release `pause`, send one tick: `value` decrements by 1.
- Expired with BLINK_TICKS = 2, sweep `pix_index` over digit cell 1 after each tick: the "0" glyph is drawn, then BG for 2 ticks, then drawn for 2 ticks; `value` stays 0 throughout.
- `start` and `tick` in the same cycle while in RUN at 05: `value` = START_VALUE and no decrement occurs.
- `rst` pulsed asynchronously mid-RUN, between clock edges: `oled` = 16'hFDDB, `value` = 0 and `done` = 0 before the next edge. y_pos = 62: no wrap artefacts appear at rows 0-2.
